// File: rtl/ofm_requant_fifo_pkg.sv
// Shared constants and helpers for the OFM requantisation output stage.
package ofm_requant_fifo_pkg;

    localparam int OFM_FRAME_LEN = 36;   // 6x6 pooled map
    localparam int OFM_W         = 36;   // pooled element width from the max-pool engine
    localparam int OFM_OUT_W     = 16;
    localparam int OFM_SHIFT     = 8;

    // Largest value representable in a w-bit two's complement word.
    function automatic longint sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic longint sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ofm_requant_fifo_if.sv
// Pooled-element input stream and requantised valid/ready output bundle.
interface ofm_requant_fifo_if
    import ofm_requant_fifo_pkg::*;
#(
    parameter int IN_W  = OFM_W,
    parameter int OUT_W = OFM_OUT_W
) ();

    logic                    in_valid;
    logic signed [IN_W-1:0]  In_OFM;
    logic                    err_clr;
    logic                    out_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] Out_Data;
    logic                    out_last;
    logic                    overflow_err;

    // Upstream/consumer side: drives the element stream and the ready.
    modport master (
        output in_valid, In_OFM, err_clr, out_ready,
        input  out_valid, Out_Data, out_last, overflow_err
    );

    // Requantiser side.
    modport slave (
        input  in_valid, In_OFM, err_clr, out_ready,
        output out_valid, Out_Data, out_last, overflow_err
    );

endinterface

// File: rtl/ofm_requant_fifo_sync_fifo.sv
// Small synchronous FIFO with a raw head-of-queue read port (first-word-fall-through).
module ofm_requant_fifo_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count is unchanged on simultaneous push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_requant_fifo.sv
// Requantises the pooled OFM stream (ReLU, rounding shift, saturation),
// tags frame ends and buffers results behind a valid/ready output.
module ofm_requant_fifo
    import ofm_requant_fifo_pkg::*;
#(
    parameter int IN_W      = OFM_W,
    parameter int OUT_W     = OFM_OUT_W,
    parameter int SHIFT     = OFM_SHIFT,
    parameter int RELU_EN   = 1,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = OFM_FRAME_LEN
) (
    input logic               clk,
    input logic               rst_n,
    ofm_requant_fifo_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int FW    = OUT_W + 1;
    localparam int AW    = $clog2(DEPTH);

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [IN_W:0] HALF =
        (SHIFT > 0) ? ((IN_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'(sat_hi(OUT_W));
    localparam logic signed [IN_W:0] SAT_LO = (IN_W + 1)'(sat_lo(OUT_W));

    function automatic logic signed [IN_W-1:0] relu(input logic signed [IN_W-1:0] x);
        if (RELU_EN != 0 && x < 0) return '0;
        return x;
    endfunction

    // One extra bit of headroom so adding HALF to the most positive input cannot wrap.
    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] e;
        e = {x[IN_W-1], x};
        e = e + HALF;
        return e >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] r);
        if (r > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    logic                    vld_p1;
    logic signed [OUT_W-1:0] data_p1;
    logic                    last_p1;
    logic [CNT_W-1:0]        elem_cnt;
    logic                    last_elem;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [FW-1:0]           dout;
    logic [AW:0]             count;
    logic                    full;
    logic                    empty;

    assign last_elem = (elem_cnt == CNT_W'(FRAME_LEN - 1));

    // Stage 1 control: valid pipe and frame position, which advances even for
    // elements later dropped so frame alignment survives an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            elem_cnt <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
            end
        end
    end

    // Stage 1 data: requantised element and its end-of-frame tag.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            data_p1 <= saturate(round_shift(relu(bus.In_OFM)));
            last_p1 <= last_elem;
        end
    end

    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = vld_p1 && (!full || pop);
    assign drop          = vld_p1 && full && !pop;
    assign bus.Out_Data  = empty ? '0 : dout[OUT_W-1:0];
    assign bus.out_last  = empty ? 1'b0 : dout[OUT_W];

    ofm_requant_fifo_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({last_p1, data_p1}),
        .dout  (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow_err <= 1'b0;
        end else if (drop) begin
            bus.overflow_err <= 1'b1;
        end else if (bus.err_clr) begin
            bus.overflow_err <= 1'b0;
        end
    end

endmodule

// File: doc/ofm_requant_fifo.md
Name: ofm_requant_fifo

Overview:
- Downstream stage of the convolution/max-pool engine. Consumes its 36-bit pooled OFM stream, one element per cycle with no backpressure.
- Per element: optional ReLU, round-half-up right shift, saturation to OUT_W bits.
- Results are buffered in a small FIFO and presented on a valid/ready interface.
- Tags the last element of each FRAME_LEN-element frame and flags data loss when the FIFO overflows.

Parameters:
- IN_W, 36, input element width (signed two's complement).
- OUT_W, 16, output width (signed two's complement).
- SHIFT, 8, arithmetic right-shift amount, 0..IN_W-1. Rounding is applied when SHIFT>0.
- RELU_EN, 1, when 1, negative inputs become 0 before shifting.
- DEPTH, 8, FIFO entries, power of two, ≥2.
- FRAME_LEN, 36, elements per frame (6x6 pooled map).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input element valid (driven by the pooling engine's out_valid).
- In_OFM  in  IN_W  pooled element, signed.
- err_clr  in  1  synchronous clear of overflow_err.
- out_ready  in  1  consumer accepts the current output.
- out_valid  out  1  Out_Data and out_last are valid.
- Out_Data  out  OUT_W  requantised element, signed.
- out_last  out  1  element is the last of its frame.
- overflow_err  out  1  sticky flag: at least one element was dropped.

Behaviour:
- **Reset:** one clock; reset is asynchronous and active-low (rst_n), synchronous deassertion assumed upstream. On reset, every output is 0, FIFO pointers and count are 0, the element counter is 0 and the stage-1 valid is 0. Reset mid-frame discards all buffered data, and the next in_valid element is index 0.
- **Stage 1** (registered, 1 cycle), applied on in_valid:
  - x = In_OFM. If RELU_EN and x<0, then x=0.
  - If SHIFT>0, r = (x + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits so the add cannot overflow. Otherwise r = x.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register {data, last}, where last = (elem_cnt == FRAME_LEN-1).
- **Element counter:** increments on every in_valid, including dropped elements, so frame alignment survives overflow. Wraps FRAME_LEN-1 → 0.
- **FIFO write:** occurs when stage-1 is valid and (count<DEPTH or a pop happens in the same cycle).
- **Overflow:** if the FIFO is full with no pop, the element is dropped and overflow_err is set on the next edge.
  - overflow_err stays set until err_clr.
  - If err_clr and a new drop coincide, the drop wins: the flag stays 1.
- **Output:** first-word-fall-through. out_valid = (count>0), and Out_Data/out_last reflect the head entry.
  - Pop when out_valid && out_ready.
  - Data is held stable while out_valid && !out_ready.
  - Out_Data and out_last read 0 when the FIFO is empty.
- **Latency:** in_valid at edge T, with the FIFO empty, gives out_valid high after edge T+2.
- **Throughput:** 1 element/cycle sustained when out_ready stays high.
- **Pointers:** log2(DEPTH)-bit pointers wrap naturally. count is log2(DEPTH)+1 bits.
- **Simultaneous push and pop:** count is unchanged.

Decomposition:
- **Shared package:** OFM_FRAME_LEN=36, OFM_W=36, default OUT_W/SHIFT constants, and a saturation-bounds function.
- **Sub-module sync_fifo:** parameters WIDTH=OUT_W+1 and DEPTH; ports push, pop, din, dout, count, full, empty.
- **Top level:** stage-1 requant logic, element counter and error flag.

Test Plan (defaults):
1. **Rounding:** In_OFM=384 → Out_Data=2 (1.5 rounds up). 767 → 3. 127 → 0. Each out_valid appears 2 cycles after in_valid.
2. **ReLU:** In_OFM=-1000 (36'hFFFFFFC18) → Out_Data=0. With RELU_EN=0: -1000 → -4 ((-1000+128)>>>8 = -3.40…, floor → -4).
3. **Saturation:** In_OFM=36'h00FFFFFFF → 16'h7FFF. With RELU_EN=0, 36'h800000000 → 16'h8000.
4. **Full frame:** 36 consecutive inputs 256·k (k=0..35) with out_ready=1 → outputs 0..35 in order, out_last only with value 35. overflow_err=0.
5. **Backpressure and overflow:** out_ready=0, 10 back-to-back inputs 256·k → 8 stored; k=8 and k=9 dropped; overflow_err=1. After out_ready=1 → outputs 0..7, then out_valid=0. The next frame's last tag lands on the element after 26 more inputs. err_clr pulse → overflow_err=0.
6. **Reset mid-frame:** 20 inputs, rst_n low for 1 cycle, then 36 inputs → out_valid=0 during reset, FIFO emptied, out_last on the 36th post-reset element.
